// File: rtl/fir_tdm_multichannel.sv
// Folded multichannel FIR: one multiplier walks all taps for each accepted sample,
// with per-channel circular histories and a shared runtime-loadable coefficient bank.
module fir_tdm_multichannel #(
    parameter int DATA_IN_WIDTH  = 16,
    parameter int TAP_WIDTH      = 32,
    parameter int TAP_COUNT      = 102,
    parameter int CHANNELS       = 2,
    parameter int ACC_WIDTH      = 64,
    parameter int OUT_SHIFT      = 31,
    parameter int DATA_OUT_WIDTH = 16,
    localparam int AW = $clog2(TAP_COUNT),
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             coef_wr_en,
    input  logic [AW-1:0]                    coef_wr_addr,
    input  logic signed [TAP_WIDTH-1:0]      coef_wr_data,
    output logic                             coef_busy,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [CW-1:0]                    in_channel,
    input  logic signed [DATA_IN_WIDTH-1:0]  data_in,
    output logic                             out_valid,
    output logic [CW-1:0]                    out_channel,
    output logic signed [DATA_OUT_WIDTH-1:0] data_out,
    output logic                             sat_flag
);
    localparam int PW = DATA_IN_WIDTH + TAP_WIDTH;
    localparam logic [CW:0] CH_LIMIT = (CW + 1)'(CHANNELS);
    localparam logic [AW:0] TAP_LIMIT = (AW + 1)'(TAP_COUNT);
    localparam logic [AW-1:0] LAST_TAP = AW'(TAP_COUNT - 1);
    localparam logic signed [ACC_WIDTH:0] SAT_MAX =
        {{(ACC_WIDTH - DATA_OUT_WIDTH + 2){1'b0}}, {(DATA_OUT_WIDTH - 1){1'b1}}};
    localparam logic signed [ACC_WIDTH:0] SAT_MIN =
        {{(ACC_WIDTH - DATA_OUT_WIDTH + 2){1'b1}}, {(DATA_OUT_WIDTH - 1){1'b0}}};

    if (ACC_WIDTH < DATA_IN_WIDTH + TAP_WIDTH + $clog2(TAP_COUNT)) begin : g_acc_check
        $error("ACC_WIDTH too small for worst-case accumulation");
    end
    if (TAP_COUNT < 2 || CHANNELS < 1) begin : g_param_check
        $error("TAP_COUNT must be >= 2 and CHANNELS >= 1");
    end

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    state_t                            state;
    logic signed [TAP_WIDTH-1:0]       coef [TAP_COUNT];
    logic signed [DATA_IN_WIDTH-1:0]   hist [CHANNELS][TAP_COUNT];
    logic [AW-1:0]                     wp   [CHANNELS];
    logic [AW-1:0]                     base;
    logic [AW-1:0]                     k;
    logic [CW-1:0]                     ch;
    logic signed [ACC_WIDTH-1:0]       acc;

    logic [AW:0]                       rd_wrap;
    logic [AW-1:0]                     rd_idx;
    logic signed [PW-1:0]              prod;
    logic signed [ACC_WIDTH-1:0]       prod_ext;
    logic signed [ACC_WIDTH:0]         rnd;

    assign in_ready  = (state == IDLE);
    assign coef_busy = (state != IDLE);

    // Newest sample sits at base; tap k reads k positions back, wrapping below zero.
    assign rd_wrap  = {1'b0, base} + TAP_LIMIT - {1'b0, k};
    assign rd_idx   = (base >= k) ? (base - k) : rd_wrap[AW-1:0];
    assign prod     = coef[k] * hist[ch][rd_idx];
    assign prod_ext = {{(ACC_WIDTH - PW){prod[PW-1]}}, prod};

    if (OUT_SHIFT == 0) begin : g_no_round
        assign rnd = $signed({acc[ACC_WIDTH-1], acc});
    end else begin : g_round
        localparam logic signed [ACC_WIDTH:0] HALF = (ACC_WIDTH + 1)'(1) << (OUT_SHIFT - 1);
        assign rnd = ($signed({acc[ACC_WIDTH-1], acc}) + HALF) >>> OUT_SHIFT;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            base        <= '0;
            k           <= '0;
            ch          <= '0;
            acc         <= '0;
            out_valid   <= 1'b0;
            out_channel <= '0;
            data_out    <= '0;
            sat_flag    <= 1'b0;
            for (int t = 0; t < TAP_COUNT; t++) coef[t] <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                wp[c] <= '0;
                for (int t = 0; t < TAP_COUNT; t++) hist[c][t] <= '0;
            end
        end else begin
            out_valid <= 1'b0;
            if (coef_wr_en && state == IDLE && {1'b0, coef_wr_addr} < TAP_LIMIT)
                coef[coef_wr_addr] <= coef_wr_data;
            case (state)
                IDLE: begin
                    // Out-of-range channels complete the handshake but are dropped.
                    if (in_valid && {1'b0, in_channel} < CH_LIMIT) begin
                        hist[in_channel][wp[in_channel]] <= data_in;
                        base <= wp[in_channel];
                        wp[in_channel] <= (wp[in_channel] == LAST_TAP) ? '0 : wp[in_channel] + 1'b1;
                        acc   <= '0;
                        k     <= '0;
                        ch    <= in_channel;
                        state <= MAC;
                    end
                end
                MAC: begin
                    acc <= acc + prod_ext;
                    if (k == LAST_TAP) state <= OUT;
                    else k <= k + 1'b1;
                end
                OUT: begin
                    if (rnd > SAT_MAX) begin
                        data_out <= SAT_MAX[DATA_OUT_WIDTH-1:0];
                        sat_flag <= 1'b1;
                    end else if (rnd < SAT_MIN) begin
                        data_out <= SAT_MIN[DATA_OUT_WIDTH-1:0];
                        sat_flag <= 1'b1;
                    end else begin
                        data_out <= rnd[DATA_OUT_WIDTH-1:0];
                        sat_flag <= 1'b0;
                    end
                    out_channel <= ch;
                    out_valid   <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/fir_tdm_multichannel.md
# fir_tdm_multichannel

Folded, time-multiplexed FIR filter with one multiplier. It is the parametrised successor to the fully pipelined fixed-coefficient FIR. It serves CHANNELS interleaved input streams, each with its own sample history, and shares one runtime-loadable coefficient bank across them. Outputs pass through rounding, shifting and saturation, and the block uses a valid/ready handshake on both sides of the sample path.

## Interface
- DATA_IN_WIDTH, 16: signed input sample width.
- TAP_WIDTH, 32: signed coefficient width (Q1.31 by default).
- TAP_COUNT, 102: number of taps; must be ≥ 2.
- CHANNELS, 2: number of independent sample histories; must be ≥ 1.
- ACC_WIDTH, 64: accumulator width; must be ≥ DATA_IN_WIDTH+TAP_WIDTH+$clog2(TAP_COUNT), otherwise elaboration fails.
- OUT_SHIFT, 31: arithmetic right shift applied after rounding; 0 means no rounding and no shift.
- DATA_OUT_WIDTH, 16: signed, saturated output width.
- clk  in  1  sole clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- coef_wr_en  in  1  coefficient write strobe.
- coef_wr_addr  in  $clog2(TAP_COUNT)  tap index of the write.
- coef_wr_data  in  TAP_WIDTH  signed coefficient value.
- coef_busy  out  1  high when state is not IDLE; coefficient writes are dropped while it is high.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept a sample (state IDLE).
- in_channel  in  max(1,$clog2(CHANNELS))  channel of the input sample.
- data_in  in  DATA_IN_WIDTH  signed input sample.
- out_valid  out  1  one-cycle pulse marking a valid result.
- out_channel  out  max(1,$clog2(CHANNELS))  channel of the result.
- data_out  out  DATA_OUT_WIDTH  signed filtered sample.
- sat_flag  out  1  result was clipped; meaningful only while out_valid is high.

## Operation
- Storage:
  - coef[0..TAP_COUNT-1] register bank.
  - hist[ch][0..TAP_COUNT-1] circular buffer per channel, with write pointer wp[ch].
- State machine IDLE → MAC → OUT → IDLE.
- IDLE:
  - in_ready = 1.
  - A sample is accepted on a clock edge where in_valid && in_ready.
  - On acceptance: hist[ch][wp[ch]] ← data_in, the latched base pointer is set to the pointer just written, wp[ch] advances modulo TAP_COUNT, acc ← 0, k ← 0, the channel is latched, and state → MAC.
  - If in_channel ≥ CHANNELS, the handshake completes but the sample is discarded: no history update and no output.
- MAC: on each edge, acc += sign-extended coef[k] * hist[ch][(base − k) mod TAP_COUNT], then k++. After the edge with k = TAP_COUNT−1, state → OUT.
- OUT: on one edge the rounded, shifted and saturated result is computed and registered, out_valid is set, and state → IDLE.
- Arithmetic:
  - r = (acc + 2^(OUT_SHIFT−1)) >>> OUT_SHIFT, i.e. round half up toward +∞.
  - If r > 2^(DATA_OUT_WIDTH−1)−1 or r < −2^(DATA_OUT_WIDTH−1), data_out is clipped to that bound and sat_flag = 1; otherwise data_out = r and sat_flag = 0.
- Coefficient writes:
  - Applied at the edge when coef_wr_en && !coef_busy.
  - A write and a sample acceptance on the same IDLE edge are both honoured, so the new coefficient is used by that sample's computation.
- Histories: a never-written history slot reads as 0.

## Timing
- in_ready is combinational from state: in_ready = (state==IDLE).
- Call the acceptance edge E0:
  - MAC occupies edges E1..E_TAP_COUNT.
  - The OUT edge is E_(TAP_COUNT+1).
  - out_valid is high for exactly the one cycle following E_(TAP_COUNT+1).
  - in_ready is high again in that same cycle.
- Latency is TAP_COUNT+1 edges from acceptance to out_valid. Maximum throughput is one sample per TAP_COUNT+2 cycles.
- data_out, out_channel and sat_flag hold their values until the next OUT edge.
- Reset values:
  - state IDLE, in_ready 1, coef_busy 0, out_valid 0.
  - data_out 0, out_channel 0, sat_flag 0.
  - All coef, hist and wp entries 0.
- Reset in MAC or OUT aborts the computation, and no out_valid is produced for the aborted sample.
- in_valid while busy is ignored; the upstream block must hold the sample until it sees in_ready.

## Test plan
- Reset, then send ch0 data_in=1000 with all coefficients at 0 → out_valid exactly TAP_COUNT+1 edges after acceptance, data_out=0, sat_flag=0; in_ready low for TAP_COUNT+1 cycles.
- Set coef[0]=0x40000000 and coef[1]=0x20000000, then send ch0 inputs 1000, 0, 0 → outputs 500, 250, 0.
- Channel isolation with the same coefficients: ch0=1000, ch1=0, ch0=0 → outputs ch0:500, ch1:0, ch0:250, with out_channel correct each time.
- Rounding: coef[0]=0x40000000, data_in=3 → 2; data_in=−3 → −1.
- Saturation: coef[0]=coef[1]=0x7FFFFFFF, two inputs of 32767 → second output 32767 with sat_flag=1; two inputs of −32768 → −32768 with sat_flag=1.
- Boundary and abort cases:
  - A coefficient write while coef_busy is high is dropped, and the next result is unchanged.
  - in_channel=CHANNELS produces no out_valid.
  - Reset asserted at MAC cycle 50 produces no out_valid, all outputs return to reset values, and in_ready=1 on the next cycle.
